// File: rtl/rr_req_agent.sv
// rr_req_agent: requester side of the req/gnt/ack round-robin protocol.
// Counts per-client request pulses, presents the pending mask as req, takes
// the same-cycle grant from the arbiter and runs a BEATS-long transfer on a
// valid/ready port for the granted owner.
// Optional feature macro: RR_REQ_AGENT_GNT_CHK_EN (grant sanity check + sticky err).
module rr_req_agent #(
    parameter int W     = 4,
    parameter int CNT_W = 2,
    parameter int BEATS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] push,
    output logic [W-1:0] full,
    output logic [W-1:0] req,
    input  logic [W-1:0] gnt,
    output logic         ack,
    output logic [W-1:0] owner,
    output logic         beat_vld,
    input  logic         beat_rdy,
    output logic         beat_last,
    output logic [W-1:0] done,
    output logic         err
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [BW-1:0]    BEAT_INIT = BW'(BEATS - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                    state_q, state_d;
    logic [W-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]              owner_q, owner_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      err_q, err_d;

    logic [W-1:0] pend;
    logic [W-1:0] gsel;
    logic         gnt_ok;
    logic         beat_fire;
`ifdef RR_REQ_AGENT_GNT_CHK_EN
    logic         gnt_bad;
`endif

    // Pending mask and full flags come straight from the registered counters
    always_comb begin
        pend = '0;
        full = '0;
        for (int i = 0; i < W; i++) begin
            pend[i] = (cnt_q[i] != '0);
            full[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    // Qualify the arbiter grant; only meaningful while idle (req is 0 when busy)
    always_comb begin
        gsel   = '0;
        gnt_ok = 1'b0;
`ifdef RR_REQ_AGENT_GNT_CHK_EN
        gnt_bad = 1'b0;
        if (state_q == IDLE && gnt != '0) begin
            if (((gnt & (gnt - 1'b1)) == '0) && ((gnt & ~pend) == '0)) begin
                gnt_ok = 1'b1;
                gsel   = gnt;
            end else begin
                gnt_bad = 1'b1;
            end
        end
`else
        // Stray grant bits are masked; the lowest surviving bit becomes owner
        if (state_q == IDLE && (gnt & pend) != '0) begin
            gnt_ok = 1'b1;
            gsel   = (gnt & pend) & (~(gnt & pend) + 1'b1);
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accepted grant starts a transfer, last accepted beat ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (gnt_ok) state_d = BUSY;
            BUSY: if (beat_fire && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state plus the combinational grant/ready inputs
    always_comb begin
        req       = '0;
        ack       = 1'b0;
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        done      = '0;
        beat_fire = 1'b0;
        case (state_q)
            IDLE: begin
                req = pend;
                ack = gnt_ok;
            end
            BUSY: begin
                beat_vld  = 1'b1;
                beat_last = (beat_q == '0);
                beat_fire = beat_rdy;
                if (beat_rdy && beat_last) done = owner_q;
            end
            default: ;
        endcase
        owner = owner_q;
        err   = err_q;
    end

    // Datapath next values: counters, owner, beat counter, sticky error
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        for (int i = 0; i < W; i++) begin
            // push and grant in the same cycle cancel; full drops the push
            if ((push[i] && !full[i]) && !(ack && gsel[i]))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!(push[i] && !full[i]) && (ack && gsel[i]))
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        if (ack) begin
            owner_d = gsel;
            beat_d  = BEAT_INIT;
        end else if (beat_fire && beat_last) begin
            owner_d = '0;
        end else if (beat_fire) begin
            beat_d  = beat_q - 1'b1;
        end
`ifdef RR_REQ_AGENT_GNT_CHK_EN
        err_d = err_q | gnt_bad;
`else
        err_d = 1'b0;
`endif
    end

    // Datapath registers; reset abandons any in-flight transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rr_req_agent.sv
// Scoreboard bench for rr_req_agent with a behavioural round-robin arbiter.
// Expected transfer owners are queued by the stimulus; a monitor pops one on
// every done pulse. Directed timing checks run inline with the stimulus.
module tb_rr_req_agent;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] push;
    logic [W-1:0] full;
    logic [W-1:0] req;
    logic [W-1:0] gnt;
    logic         ack;
    logic [W-1:0] owner;
    logic         beat_vld;
    logic         beat_rdy;
    logic         beat_last;
    logic [W-1:0] done;
    logic         err;

    logic         force_en;
    logic [W-1:0] force_val;
    logic [W-1:0] rr_g;
    int           ptr;
    int           cyc;
    int           n_chk;
    int           n_fail;
    int           first_ack_cyc;
    int           last_done_cyc;
    logic [W-1:0] exp_q[$];

    rr_req_agent #(.W(W), .CNT_W(2), .BEATS(2)) dut (
        .clk(clk), .rst(rst), .push(push), .full(full), .req(req), .gnt(gnt),
        .ack(ack), .owner(owner), .beat_vld(beat_vld), .beat_rdy(beat_rdy),
        .beat_last(beat_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin arbiter model: combinational grant from req, pointer moves on ack
    always_comb begin
        int idx;
        logic found;
        rr_g  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < W; k++) begin
            idx = (ptr + k) % W;
            if (!found && req[idx]) begin
                rr_g[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        gnt = force_en ? force_val : rr_g;
    end

    always @(posedge clk) begin
        if (rst) ptr <= 0;
        else if (ack)
            for (int k = W - 1; k >= 0; k--)
                if ((gnt[k] & req[k]) == 1'b1) ptr <= (k + 1) % W;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the next queued owner and be a last beat
    always @(negedge clk) begin
        if (!rst && done != '0) begin
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {28'd0, done}, 32'd0);
            end else begin
                chk("done_owner", {28'd0, done}, {28'd0, exp_q.pop_front()});
                chk("done_on_last", {31'd0, beat_last}, 32'd1);
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        push      = '0;
        beat_rdy  = 1'b1;
        force_en  = 1'b0;
        force_val = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [W-1:0] v);
        push = v;
        @(posedge clk);
        #1;
        push = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_fail = 0;
        first_ack_cyc = 0; last_done_cyc = 0;
        do_reset();

        // Reset state, then idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {28'd0, req}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_owner", {28'd0, owner}, 32'd0);
        chk("rst_vld", {31'd0, beat_vld}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_full", {28'd0, full}, 32'd0);

        // Single request, single transfer, cycle by cycle
        @(posedge clk); #1;
        exp_q.push_back(4'b0001);
        pulse(4'b0001);
        @(negedge clk);
        chk("t1_req", {28'd0, req}, 32'h1);
        chk("t1_ack", {31'd0, ack}, 32'd1);
        @(negedge clk);
        chk("t1_ack_drop", {31'd0, ack}, 32'd0);
        chk("t1_owner", {28'd0, owner}, 32'h1);
        chk("t1_beat0", {30'd0, beat_vld, beat_last}, 32'h2);
        chk("t1_busy_req", {28'd0, req}, 32'd0);
        @(negedge clk);
        chk("t1_beat1", {30'd0, beat_vld, beat_last}, 32'h3);
        chk("t1_done", {28'd0, done}, 32'h1);
        @(negedge clk);
        chk("t1_idle", {27'd0, beat_vld, owner}, 32'd0);
        chk("t1_req_clr", {28'd0, req}, 32'd0);
        drain("t1_drain", 10);

        // All four clients: round-robin order, 12 cycles first ack to last done
        do_reset();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        pulse(4'b1111);
        @(negedge clk);
        chk("t2_ack", {31'd0, ack}, 32'd1);
        first_ack_cyc = cyc;
        drain("t2_drain", 40);
        chk("t2_span", last_done_cyc - first_ack_cyc + 1, 32'd12);

        // Saturating counter: five pushes, only three stick
        do_reset();
        force_en = 1'b1;
        force_val = '0;
        for (int i = 0; i < 5; i++) begin
            push = 4'b0100;
            @(posedge clk);
            #1;
            if (i == 1) chk("t3_not_full", {28'd0, full}, 32'd0);
            if (i == 2) chk("t3_full", {28'd0, full}, 32'h4);
        end
        push = '0;
        chk("t3_full_hold", {28'd0, full}, 32'h4);
        chk("t3_req", {28'd0, req}, 32'h4);
        repeat (3) exp_q.push_back(4'b0100);
        force_en = 1'b0;
        drain("t3_drain", 40);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_req_end", {28'd0, req}, 32'd0);
        chk("t3_full_end", {28'd0, full}, 32'd0);

        // Downstream back-pressure: four stalled cycles
        do_reset();
        beat_rdy = 1'b0;
        exp_q.push_back(4'b0001);
        pulse(4'b0001);
        @(negedge clk);
        chk("t4_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall_beat", {30'd0, beat_vld, beat_last}, 32'h2);
            chk("t4_stall_done", {28'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        beat_rdy = 1'b1;
        @(negedge clk);
        chk("t4_beat0", {30'd0, beat_vld, beat_last}, 32'h2);
        chk("t4_beat0_done", {28'd0, done}, 32'd0);
        @(negedge clk);
        chk("t4_beat1", {30'd0, beat_vld, beat_last}, 32'h3);
        drain("t4_drain", 10);

        // Malformed grant handling
        do_reset();
        force_en = 1'b1;
        force_val = '0;
        pulse(4'b0011);
        force_val = 4'b0011;
`ifdef RR_REQ_AGENT_GNT_CHK_EN
        @(negedge clk);
        chk("t5_bad_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        force_val = 4'b0100;
        @(negedge clk);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_no_owner", {27'd0, beat_vld, owner}, 32'd0);
        chk("t5_req_kept", {28'd0, req}, 32'h3);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        @(posedge clk); #1;
        force_en = 1'b0;
        drain("t5_drain", 20);
        chk("t5_err_sticky", {31'd0, err}, 32'd1);
`else
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        @(negedge clk);
        chk("t5_multi_ack", {31'd0, ack}, 32'd1);
        @(posedge clk); #1;
        force_en = 1'b0;
        chk("t5_low_owner", {28'd0, owner}, 32'h1);
        chk("t5_err0", {31'd0, err}, 32'd0);
        drain("t5_drain", 20);
`endif

        // Reset in the middle of a transfer: no done, counters cleared
        do_reset();
        chk("t6_err_clr", {31'd0, err}, 32'd0);
        beat_rdy = 1'b0;
        push = 4'b0010;
        @(posedge clk); #1;
        pulse(4'b0010);
        @(negedge clk);
        chk("t6_busy", {28'd0, owner}, 32'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_owner", {28'd0, owner}, 32'd0);
        chk("t6_vld", {31'd0, beat_vld}, 32'd0);
        chk("t6_req", {28'd0, req}, 32'd0);
        beat_rdy = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t6_quiet", {28'd0, owner}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
